// File: rtl/display_scan_refresher.sv
// display_scan_refresher
// Divides Clk into a one-cycle Refresh strobe every CLK_DIV enabled cycles.
// Each strobe steps DigitSel through 0..NUM_DIGITS-1 and rotates a one-hot
// anode pattern for a multiplexed seven-segment display. FrameDone marks the
// wrap back to digit 0.
// Optional macro BLANKING_EN adds a dead-time counter. After each Refresh,
// it blanks all anodes for BLANK_CYCLES enabled cycles.
module display_scan_refresher #(
    parameter int CLK_DIV          = 100000,
    parameter int NUM_DIGITS       = 4,
    parameter int SEL_W            = 2,
    parameter int CNT_W            = 17,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int BLANK_CYCLES     = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  En,
    output logic                  Refresh,
    output logic [SEL_W-1:0]      DigitSel,
    output logic [NUM_DIGITS-1:0] Anode,
    output logic                  FrameDone,
    output logic                  Blank
);

    // Last divider count of a period and last legal digit index.
    localparam logic [CNT_W-1:0]      DIV_LAST     = CNT_W'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0]      SEL_LAST     = SEL_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONEHOT_FIRST = NUM_DIGITS'(1);
    // XOR mask that turns an active-high one-hot into the pin polarity.
    localparam logic [NUM_DIGITS-1:0] POL_MASK     =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      div_next;
    logic                  refresh_next;
    logic [SEL_W-1:0]      sel_next;
    logic                  frame_next;
    logic [NUM_DIGITS-1:0] onehot;
    logic [NUM_DIGITS-1:0] onehot_next;
    logic [NUM_DIGITS-1:0] anode_enable_next;
    logic                  period_end;
    logic                  digit_wrap;

    assign period_end = (div_cnt == DIV_LAST);
    assign digit_wrap = (DigitSel == SEL_LAST);

`ifdef BLANKING_EN
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] blank_cnt;
    logic [CNT_W-1:0] blank_next;

    // Dead-time counter: loaded on every Refresh edge, counts down on enabled edges.
    always_comb begin
        blank_next = blank_cnt;
        if (En) begin
            if (period_end) begin
                blank_next = BLANK_LOAD;
            end else if (blank_cnt != '0) begin
                blank_next = blank_cnt - CNT_W'(1);
            end
        end
    end

    // Blank counter register; the Blank output reflects the registered count directly.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            blank_cnt <= '0;
        end else begin
            blank_cnt <= blank_next;
        end
    end

    assign Blank             = (blank_cnt != '0);
    assign anode_enable_next = (blank_next != '0) ? '0 : onehot_next;
`else
    assign Blank             = 1'b0;
    assign anode_enable_next = onehot_next;
`endif

    // Next-state for the divider and digit scan.
    // En low holds div_cnt, DigitSel and Anode, and suppresses both strobes.
    always_comb begin
        div_next     = div_cnt;
        refresh_next = 1'b0;
        sel_next     = DigitSel;
        frame_next   = 1'b0;
        onehot_next  = onehot;
        if (En) begin
            if (period_end) begin
                div_next     = '0;
                refresh_next = 1'b1;
                onehot_next  = {onehot[NUM_DIGITS-2:0], onehot[NUM_DIGITS-1]};
                if (digit_wrap) begin
                    sel_next   = '0;
                    frame_next = 1'b1;
                end else begin
                    sel_next = DigitSel + SEL_W'(1);
                end
            end else begin
                div_next = div_cnt + CNT_W'(1);
            end
        end
    end

    // Registered state and outputs.
    // Reset selects digit 0 and restarts the period from zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_cnt   <= '0;
            Refresh   <= 1'b0;
            DigitSel  <= '0;
            FrameDone <= 1'b0;
            onehot    <= ONEHOT_FIRST;
            Anode     <= ONEHOT_FIRST ^ POL_MASK;
        end else begin
            div_cnt   <= div_next;
            Refresh   <= refresh_next;
            DigitSel  <= sel_next;
            FrameDone <= frame_next;
            onehot    <= onehot_next;
            Anode     <= anode_enable_next ^ POL_MASK;
        end
    end

endmodule

// File: doc/display_scan_refresher.md
Name: display_scan_refresher

Overview:
Parametrised successor to the single-output refresh-pulse generator. Divides the system clock into a periodic one-cycle Refresh strobe and uses it to step a digit-select counter across NUM_DIGITS positions. Drives one-hot anode enables for a multiplexed seven-segment display. Sits between the system clock/reset and the segment decoder/mux; the decoder uses DigitSel to pick the value to show.

Parameters:
CLK_DIV, 100000, Clk cycles per Refresh period; legal range ≥1 (≥2 when BLANKING_EN is defined).
NUM_DIGITS, 4, number of scanned digits; legal range 2..2**SEL_W.
SEL_W, 2, width of DigitSel.
CNT_W, 17, width of the divider counter; must satisfy 2**CNT_W ≥ CLK_DIV.
ANODE_ACTIVE_LOW, 1, 1 = enabled anode driven 0, others 1; 0 = inverse polarity.
BLANK_CYCLES, 16, dead-time length in Clk cycles; used only with BLANKING_EN; legal range 1..CLK_DIV-1.

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst  input  1  synchronous, active-high reset
En  input  1  scan enable; low freezes the scan
Refresh  output  1  one-cycle strobe per CLK_DIV enabled cycles
DigitSel  output  SEL_W  index of the active digit, 0..NUM_DIGITS-1
Anode  output  NUM_DIGITS  one-hot digit enables, polarity per ANODE_ACTIVE_LOW
FrameDone  output  1  one-cycle strobe when DigitSel wraps to 0
Blank  output  1  high during dead-time (always 0 without BLANKING_EN)

Behaviour:
- Reset: Clk and reset are fixed. One clock, Clk. Reset Rst is synchronous and active-high. At a rising edge with Rst=1, state is set as follows:
  - div_cnt=0, Refresh=0, FrameDone=0, DigitSel=0, Blank=0.
  - Anode selects digit 0: bit0 active, all other bits inactive.
  - Rst overrides En and any in-progress period or blanking.
- Divider: on each edge with En=1 and Rst=0:
  - If div_cnt==CLK_DIV-1: div_cnt<=0 and Refresh<=1.
  - Otherwise: div_cnt<=div_cnt+1 and Refresh<=0.
- Refresh timing: Refresh is registered, so it is high for exactly one cycle. The first Refresh is visible after the CLK_DIV-th enabled edge following reset release. Later strobes follow every CLK_DIV enabled edges.
- CLK_DIV=1: Refresh stays high on every enabled cycle.
- Digit step: on the same edge that sets Refresh, DigitSel<=DigitSel+1. When DigitSel==NUM_DIGITS-1 it wraps to 0 instead. The new DigitSel, the new Anode and Refresh become visible in the same cycle. Values ≥NUM_DIGITS never appear.
- FrameDone: set to 1 for one cycle on the edge where DigitSel wraps from NUM_DIGITS-1 to 0. It is always coincident with a Refresh.
- Anode: registered and updated on the same edge as DigitSel. Exactly one bit is active when Blank=0.
- En=0:
  - div_cnt, DigitSel and Anode hold their values.
  - Refresh<=0 and FrameDone<=0; a pending strobe is not emitted.
  - On re-enable, counting resumes from the held div_cnt.
- Reset mid-operation: Rst asserted for one cycle anywhere restores the reset values on the next edge. The period restarts from div_cnt=0.

Optional Feature:
Macro BLANKING_EN.
- Defined: every Refresh edge also loads a blank counter with BLANK_CYCLES.
  - While the counter is nonzero, Blank=1 and all Anode bits are inactive. The counter decrements on enabled edges only.
  - Blank=1 therefore lasts exactly BLANK_CYCLES enabled cycles, starting in the Refresh cycle. The new digit's anode becomes active in the following cycle.
  - En=0 freezes the blank counter. Rst clears it.
- Undefined: no blank counter is built, Blank is tied 0, and Anode switches directly on Refresh.

Test Plan:
1. Divider: CLK_DIV=5, NUM_DIGITS=3, En=1, Rst high for 2 edges then low. Refresh is high on cycles 5, 10, 15, 20 after release and low otherwise. DigitSel runs 0→1→2→0→1. FrameDone is high only in cycle 15.
2. Anode polarity: ANODE_ACTIVE_LOW=1, NUM_DIGITS=4. Anode steps 1110→1101→1011→0111→1110. Repeat with ANODE_ACTIVE_LOW=0: Anode steps 0001→0010→0100→1000→0001.
3. Enable freeze: CLK_DIV=5, drop En for 7 cycles when div_cnt=3. No Refresh during the freeze and DigitSel is unchanged. The next Refresh arrives 2 enabled cycles after En returns high.
4. Reset mid-period: CLK_DIV=5, assert Rst for one cycle when DigitSel=2 and div_cnt=4. DigitSel=0, Refresh=0 and Anode shows digit 0. The next Refresh comes 5 cycles after release.
5. CLK_DIV=1, NUM_DIGITS=2: Refresh stays high continuously, DigitSel toggles 0/1 every cycle, and FrameDone is high every second cycle.
6. BLANKING_EN defined, CLK_DIV=8, BLANK_CYCLES=3: after each Refresh, Blank=1 and all anodes are inactive for exactly 3 cycles, then the new digit is active for 5 cycles. Asserting Rst during blanking gives Blank=0 on the next cycle.
